alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
- Upstream-side encoder and controller for the self-checking 3-bit ALU datapath.
- Takes raw requests (operands plus 2-bit opcode) over a valid/ready handshake and encodes them into the codewords the checkers consume: odd-parity operand word and one-hot control.
- Drives the ALU, samples the two-rail checker outputs, and retries on a detected error before returning a result with a status code.

Parameters:
SETTLE, 1, cycles the encoded operands are held on the ALU before checkers and result are sampled (legal range 1..15)
MAX_RETRY, 2, retries allowed after a failed sample before reporting an uncorrectable error (legal range 0..7)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  issuer can accept a request
req_a  in  3  operand A
req_b  in  3  operand B
req_op  in  2  00 ADD (A+B), 01 SUB (A-B), 10 RSUB (B-A), 11 illegal
alu_a  out  3  encoded operand A to ALU
alu_b  out  3  encoded operand B to ALU
alu_p  out  1  odd parity bit over {alu_a, alu_b, alu_p}
alu_c  out  3  one-hot control: ADD 001, SUB 010, RSUB 100
alu_x  in  3  ALU result
alu_xc  in  1  ALU carry-out
in_chk_x, in_chk_xb  in  1 each  two-rail output of the input-code (parity/one-hot) checker
out_chk_x, out_chk_xb  in  1 each  two-rail output of the duplicated-result checker
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_x  out  3  captured result
rsp_xc  out  1  captured carry
rsp_err  out  2  00 clean, 01 recovered after retry, 10 uncorrectable, 11 illegal op
err_count  out  8  saturating count of failed samples

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; req_ready=1; rsp_valid=0; rsp_x=0; rsp_xc=0; rsp_err=00; err_count=0; retry counter=0.
  - ALU outputs take the idle codeword: alu_a=000, alu_b=000, alu_c=001, alu_p=1. This is a valid code, so the checkers stay quiet.
- States: IDLE, DRIVE, RETRY, RESP. req_ready=1 only in IDLE.
- IDLE, accept on req_valid&&req_ready at edge T0:
  - Legal op: register alu_a=req_a, alu_b=req_b, alu_c per opcode, alu_p=~(^req_a ^ ^req_b). Clear retry counter and settle counter. Go to DRIVE.
  - Illegal op (11): ALU outputs stay at the idle codeword. rsp_err=11, rsp_x=0, rsp_xc=0. Go to RESP; rsp_valid is high after T0.
- DRIVE:
  - Lasts exactly SETTLE cycles; the sample is taken at the edge that leaves DRIVE.
  - A check fails if in_chk_x==in_chk_xb or out_chk_x==out_chk_xb.
  - Every failing sample increments err_count, saturating at 255.
  - Pass: rsp_x=alu_x, rsp_xc=alu_xc; rsp_err=00 if retry count is 0, else 01. Go to RESP.
  - Fail with retry count < MAX_RETRY: increment retry count. Go to RETRY.
  - Fail with retry count == MAX_RETRY: capture alu_x and alu_xc anyway; rsp_err=10. Go to RESP.
- RETRY: lasts 1 cycle with ALU outputs forced to the idle codeword. Then re-drive the held request codeword and go to DRIVE.
- Latency:
  - Clean: rsp_valid rises at edge T0+SETTLE.
  - Each retry adds SETTLE+1 cycles.
  - Worst case: T0 + (MAX_RETRY+1)*SETTLE + MAX_RETRY.
- RESP:
  - rsp_valid=1, with rsp_x, rsp_xc and rsp_err stable until rsp_valid&&rsp_ready.
  - On the handshake, go to IDLE: rsp_valid=0, req_ready=1 next cycle, ALU outputs return to the idle codeword.
  - No request/response overlap; a req_valid held during RESP waits.
- A captured request is held internally; req_a, req_b and req_op may change after acceptance without effect.
- Reset mid-operation aborts immediately: no response is produced, and all outputs take their reset values, including err_count=0.
- Checker inputs are ignored outside the sample edge.
- Arithmetic is never computed internally; results come only from alu_x and alu_xc.

Test Plan:
- ADD, a=3, b=2, op=00, checkers valid (x=1, xb=0), SETTLE=1 -> alu_c=001, alu_p=0; rsp_valid at T0+1 with rsp_x=5, rsp_xc=0, rsp_err=00; err_count=0.
- SUB a=2, b=5 (op=01) -> alu_c=010, alu_p=0, rsp_x=101, rsp_xc=0. RSUB a=1, b=4 (op=10) -> alu_c=100, alu_p=1, rsp_x=011, rsp_xc=1. Both with rsp_err=00.
- Force in_chk_x=in_chk_xb=1 at the first sample only, SETTLE=1 -> alu outputs show the idle codeword for one cycle, then the request codeword; rsp_valid at T0+3, rsp_err=01, err_count=1.
- Persistent out_chk_x=out_chk_xb=0, MAX_RETRY=2 -> three samples, rsp_err=10 at T0+5, err_count=3. Repeat 100 times -> err_count saturates at 255.
- op=11, a=7, b=7 -> rsp_valid after T0 with rsp_err=11, rsp_x=0; alu_c stays 001 and alu_p stays 1 throughout.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp fields stable, req_ready=0. Separately, assert rst_n=0 during DRIVE -> all outputs at reset values and no rsp_valid ever appears.

Source files
------------

// File: rtl/alu_op_issuer.sv
// Encodes requests into parity/one-hot ALU codewords, samples two-rail checkers and retries on error.
// Latency SETTLE + retries*(SETTLE+1) edges; single request in flight, response held until rsp_ready.
module alu_op_issuer #(
    parameter int SETTLE    = 1,
    parameter int MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_a,
    input  logic [2:0] req_b,
    input  logic [1:0] req_op,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic       alu_p,
    output logic [2:0] alu_c,
    input  logic [2:0] alu_x,
    input  logic       alu_xc,
    input  logic       in_chk_x,
    input  logic       in_chk_xb,
    input  logic       out_chk_x,
    input  logic       out_chk_xb,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_x,
    output logic       rsp_xc,
    output logic [1:0] rsp_err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_RETRY, ST_RESP} state_t;

    localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [2:0] LP_MAX_RETRY   = 3'(MAX_RETRY);

    state_t     r_state, w_state;
    logic [3:0] r_settle, w_settle;
    logic [2:0] r_retry, w_retry;
    logic [2:0] r_hold_a, w_hold_a, r_hold_b, w_hold_b, r_hold_c, w_hold_c;
    logic       r_hold_p, w_hold_p;
    logic [2:0] r_alu_a, w_alu_a, r_alu_b, w_alu_b, r_alu_c, w_alu_c;
    logic       r_alu_p, w_alu_p;
    logic [2:0] r_rsp_x, w_rsp_x;
    logic       r_rsp_xc, w_rsp_xc;
    logic [1:0] r_rsp_err, w_rsp_err;
    logic [7:0] r_err_count, w_err_count;
    logic [2:0] w_enc_c;
    logic       w_enc_p;
    logic       w_chk_fail;

    assign w_enc_p    = ~(^req_a ^ ^req_b);
    assign w_chk_fail = (in_chk_x == in_chk_xb) || (out_chk_x == out_chk_xb);

    always_comb begin
        w_enc_c = 3'b001;
        case (req_op)
            2'b01:   w_enc_c = 3'b010;
            2'b10:   w_enc_c = 3'b100;
            default: w_enc_c = 3'b001;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_settle    <= 4'd0;
            r_retry     <= 3'd0;
            r_hold_a    <= 3'd0;
            r_hold_b    <= 3'd0;
            r_hold_c    <= 3'b001;
            r_hold_p    <= 1'b1;
            r_alu_a     <= 3'd0;
            r_alu_b     <= 3'd0;
            r_alu_c     <= 3'b001;
            r_alu_p     <= 1'b1;
            r_rsp_x     <= 3'd0;
            r_rsp_xc    <= 1'b0;
            r_rsp_err   <= 2'b00;
            r_err_count <= 8'd0;
        end else begin
            r_state     <= w_state;
            r_settle    <= w_settle;
            r_retry     <= w_retry;
            r_hold_a    <= w_hold_a;
            r_hold_b    <= w_hold_b;
            r_hold_c    <= w_hold_c;
            r_hold_p    <= w_hold_p;
            r_alu_a     <= w_alu_a;
            r_alu_b     <= w_alu_b;
            r_alu_c     <= w_alu_c;
            r_alu_p     <= w_alu_p;
            r_rsp_x     <= w_rsp_x;
            r_rsp_xc    <= w_rsp_xc;
            r_rsp_err   <= w_rsp_err;
            r_err_count <= w_err_count;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_settle    = r_settle;
        w_retry     = r_retry;
        w_hold_a    = r_hold_a;
        w_hold_b    = r_hold_b;
        w_hold_c    = r_hold_c;
        w_hold_p    = r_hold_p;
        w_alu_a     = r_alu_a;
        w_alu_b     = r_alu_b;
        w_alu_c     = r_alu_c;
        w_alu_p     = r_alu_p;
        w_rsp_x     = r_rsp_x;
        w_rsp_xc    = r_rsp_xc;
        w_rsp_err   = r_rsp_err;
        w_err_count = r_err_count;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_op == 2'b11) begin
                        // Illegal op never reaches the ALU; it stays on the idle codeword.
                        w_rsp_x   = 3'd0;
                        w_rsp_xc  = 1'b0;
                        w_rsp_err = 2'b11;
                        w_state   = ST_RESP;
                    end else begin
                        w_hold_a = req_a;
                        w_hold_b = req_b;
                        w_hold_c = w_enc_c;
                        w_hold_p = w_enc_p;
                        w_alu_a  = req_a;
                        w_alu_b  = req_b;
                        w_alu_c  = w_enc_c;
                        w_alu_p  = w_enc_p;
                        w_settle = 4'd0;
                        w_retry  = 3'd0;
                        w_state  = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (r_settle == LP_SETTLE_LAST) begin
                    if (w_chk_fail) begin
                        if (r_err_count != 8'hFF) begin
                            w_err_count = r_err_count + 8'd1;
                        end
                        if (r_retry == LP_MAX_RETRY) begin
                            w_rsp_x   = alu_x;
                            w_rsp_xc  = alu_xc;
                            w_rsp_err = 2'b10;
                            w_state   = ST_RESP;
                        end else begin
                            w_retry = r_retry + 3'd1;
                            w_alu_a = 3'd0;
                            w_alu_b = 3'd0;
                            w_alu_c = 3'b001;
                            w_alu_p = 1'b1;
                            w_state = ST_RETRY;
                        end
                    end else begin
                        w_rsp_x   = alu_x;
                        w_rsp_xc  = alu_xc;
                        w_rsp_err = (r_retry == 3'd0) ? 2'b00 : 2'b01;
                        w_state   = ST_RESP;
                    end
                end else begin
                    w_settle = r_settle + 4'd1;
                end
            end
            ST_RETRY: begin
                w_alu_a  = r_hold_a;
                w_alu_b  = r_hold_b;
                w_alu_c  = r_hold_c;
                w_alu_p  = r_hold_p;
                w_settle = 4'd0;
                w_state  = ST_DRIVE;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_alu_a = 3'd0;
                    w_alu_b = 3'd0;
                    w_alu_c = 3'b001;
                    w_alu_p = 1'b1;
                    w_state = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_c     = r_alu_c;
    assign alu_p     = r_alu_p;
    assign rsp_x     = r_rsp_x;
    assign rsp_xc    = r_rsp_xc;
    assign rsp_err   = r_rsp_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Randomized bench for alu_op_issuer: a fault-free ALU model feeds the DUT and a transaction-level
// scoreboard predicts latency, codewords, responses and the saturating error count.
module tb_alu_op_issuer;

    localparam int S  = 1;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [2:0] req_a, req_b;
    logic [1:0] req_op;
    logic [2:0] alu_a, alu_b, alu_c, alu_x;
    logic       alu_p, alu_xc;
    logic       in_chk_x, in_chk_xb, out_chk_x, out_chk_xb;
    logic       rsp_valid, rsp_ready;
    logic [2:0] rsp_x;
    logic       rsp_xc;
    logic [1:0] rsp_err;
    logic [7:0] err_count;
    logic [3:0] alu_sum;

    int errors = 0;
    int checks = 0;
    int model_err_cnt = 0;

    always #5 clk = ~clk;

    alu_op_issuer #(.SETTLE(S), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_p(alu_p), .alu_c(alu_c),
        .alu_x(alu_x), .alu_xc(alu_xc),
        .in_chk_x(in_chk_x), .in_chk_xb(in_chk_xb),
        .out_chk_x(out_chk_x), .out_chk_xb(out_chk_xb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x), .rsp_xc(rsp_xc), .rsp_err(rsp_err),
        .err_count(err_count)
    );

    // Fault-free ALU: subtraction carry is the no-borrow flag.
    always_comb begin
        alu_sum = 4'd0;
        case (alu_c)
            3'b001: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            3'b010: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 4'd1;
            3'b100: alu_sum = {1'b0, alu_b} + {1'b0, ~alu_a} + 4'd1;
            default: alu_sum = 4'd0;
        endcase
        alu_x  = alu_sum[2:0];
        alu_xc = alu_sum[3];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_chk_garbage();
        {in_chk_x, in_chk_xb, out_chk_x, out_chk_xb} = 4'($urandom);
    endtask

    task automatic set_chk(input bit fail);
        logic v;
        v = 1'($urandom);
        in_chk_x  = 1'($urandom);
        in_chk_xb = ~in_chk_x;
        out_chk_x  = 1'($urandom);
        out_chk_xb = ~out_chk_x;
        if (fail) begin
            case ($urandom_range(0, 2))
                0: begin in_chk_x = v; in_chk_xb = v; end
                1: begin out_chk_x = v; out_chk_xb = v; end
                default: begin in_chk_x = v; in_chk_xb = v; out_chk_x = ~v; out_chk_xb = ~v; end
            endcase
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_x"}, rsp_x, 0);
        chk({tag, "_rsp_xc"}, rsp_xc, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_alu_code"}, {alu_a, alu_b, alu_c, alu_p}, {3'd0, 3'd0, 3'b001, 1'b1});
    endtask

    // nfail: number of leading samples that see a checker fault.
    task automatic run_txn(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                           input int nfail, input int hold, input bit garble);
        int lat, nf_eff, ai, bi, exp_x, exp_xc, exp_err, c;
        bit illegal, idle_now;
        logic [2:0] exp_c;
        logic exp_p;

        chk("idle_req_ready", req_ready, 1);
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        set_chk_garbage();
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (garble) begin
            req_a = 3'($urandom); req_b = 3'($urandom); req_op = 2'($urandom);
        end

        illegal = (op == 2'b11);
        ai = int'(a); bi = int'(b);
        exp_c = 3'b001 << op;
        exp_p = ($countones({a, b}) % 2) == 0;
        nf_eff = illegal ? 0 : ((nfail > MR + 1) ? MR + 1 : nfail);
        lat = illegal ? 0 : S + ((nfail > MR) ? MR : nfail) * (S + 1);

        c = 0;
        while (1) begin
            chk("rsp_valid_timing", rsp_valid, (c == lat));
            idle_now = illegal || ((c < lat) && ((c % (S + 1)) == S));
            if (idle_now)
                chk("alu_idle_code", {alu_a, alu_b, alu_c, alu_p}, {3'd0, 3'd0, 3'b001, 1'b1});
            else
                chk("alu_req_code", {alu_a, alu_b, alu_c, alu_p}, {a, b, exp_c, exp_p});
            if (c >= lat) break;
            if (((c + 1) % (S + 1)) == S)
                set_chk(((c + 1) / (S + 1)) < nfail);
            else
                set_chk_garbage();
            @(posedge clk); #1;
            c++;
        end

        model_err_cnt = model_err_cnt + nf_eff;
        if (model_err_cnt > 255) model_err_cnt = 255;
        if (illegal) begin
            exp_x = 0; exp_xc = 0; exp_err = 3;
        end else begin
            case (op)
                2'b00: begin exp_x = (ai + bi) % 8; exp_xc = (ai + bi) > 7; end
                2'b01: begin exp_x = (ai - bi + 8) % 8; exp_xc = ai >= bi; end
                default: begin exp_x = (bi - ai + 8) % 8; exp_xc = bi >= ai; end
            endcase
            exp_err = (nfail == 0) ? 0 : (nfail <= MR) ? 1 : 2;
        end

        chk("rsp_x", rsp_x, exp_x);
        chk("rsp_xc", rsp_xc, exp_xc);
        chk("rsp_err", rsp_err, exp_err);
        chk("err_count", err_count, model_err_cnt);
        chk("resp_req_ready", req_ready, 0);

        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            set_chk_garbage();
            @(posedge clk); #1;
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_fields", {rsp_x, rsp_xc, rsp_err}, {3'(exp_x), 1'(exp_xc), 2'(exp_err)});
            chk("hold_req_ready", req_ready, 0);
            chk("hold_err_count", err_count, model_err_cnt);
        end

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_alu_idle", {alu_a, alu_b, alu_c, alu_p}, {3'd0, 3'd0, 3'b001, 1'b1});
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_a = 3'd0; req_b = 3'd0; req_op = 2'd0;
        rsp_ready = 1'b0;
        set_chk(1'b0);
        #12;
        check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(3'd3, 3'd2, 2'b00, 0, 0, 1'b1);
        run_txn(3'd2, 3'd5, 2'b01, 0, 0, 1'b1);
        run_txn(3'd1, 3'd4, 2'b10, 0, 0, 1'b1);
        run_txn(3'd6, 3'd3, 2'b00, 1, 0, 1'b0);
        run_txn(3'd5, 3'd5, 2'b01, 3, 0, 1'b0);
        run_txn(3'd7, 3'd7, 2'b11, 0, 2, 1'b0);
        run_txn(3'd4, 3'd6, 2'b10, 2, 5, 1'b1);

        for (int i = 0; i < 150; i++) begin
            run_txn(3'($urandom), 3'($urandom), 2'($urandom), $urandom_range(0, MR + 1),
                    $urandom_range(0, 3), 1'($urandom));
        end

        for (int i = 0; i < 100; i++) begin
            run_txn(3'($urandom), 3'($urandom), 2'($urandom_range(0, 2)), MR + 1, 0, 1'b0);
        end
        chk("err_count_saturated", err_count, 255);

        // Abort during DRIVE: everything returns to reset values and no response appears.
        req_valid = 1'b1; req_a = 3'd5; req_b = 3'd1; req_op = 2'b00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_in_flight", rsp_valid, 0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("abort");
        model_err_cnt = 0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", rsp_valid, 0);
        end
        chk("abort_req_ready", req_ready, 1);
        run_txn(3'd3, 3'd2, 2'b00, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
